// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the EX-stage shift-add multiply sequencer:
// ALU opcodes, sequencer state encoding and iteration count.
package alu_mul_sequencer_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative 32x32 -> 64 unsigned shift-add multiply that borrows the
// pipeline's single combinational ALU. While idle the ALU ports are a
// pure pass-through of the EX operands; during a multiply the pipeline is
// stalled and the ALU performs one ADD per iteration.
//
// Build option: define MUL_HIGH_EN to let mul_hi_sel return the high
// product word (MULHU). Without it mul_result is always the low word.
//
// state | meaning
// IDLE  | pass-through, waiting for mul_start
// RUN   | 32 add/shift iterations, pipeline stalled
// DONE  | one-cycle result pulse, stall released
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [3:0]      ex_alu_control,
    input  logic            mul_start,
    input  logic            mul_hi_sel,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    output logic            stall,
    output logic            mul_done,
    output logic [XLEN-1:0] mul_result
);

    mul_state_e       state_q;
    logic [XLEN-1:0]  m_q;
    logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  mul_result_q;
    logic             mul_done_q;
    logic [XLEN-1:0]  sum;
    logic             carry;
    logic [XLEN-1:0]  result_word;

    // One add/shift step: the ALU has no carry out, so recover it by
    // noticing the unsigned sum wrapped below the addend.
    always_comb begin
        sum   = acc_hi_q;
        carry = 1'b0;
        if (acc_lo_q[0]) begin
            sum   = alu_result;
            carry = (alu_result < acc_hi_q);
        end
        acc_hi_d = {carry, sum[XLEN-1:1]};
        acc_lo_d = {sum[0], acc_lo_q[XLEN-1:1]};
    end

`ifdef MUL_HIGH_EN
    assign result_word = mul_hi_sel ? acc_hi_q : acc_lo_q;
`else
    logic unused_hi_sel;
    assign unused_hi_sel = mul_hi_sel;
    assign result_word   = acc_lo_q;
`endif

    // ALU mux and stall: borrow the ALU only while iterating.
    always_comb begin
        alu_a       = ex_a;
        alu_b       = ex_b;
        alu_control = ex_alu_control;
        stall       = 1'b0;
        case (state_q)
            IDLE: stall = mul_start;
            RUN: begin
                alu_a       = acc_hi_q;
                alu_b       = m_q;
                alu_control = ALU_ADD;
                stall       = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    assign mul_done   = mul_done_q;
    assign mul_result = (state_q == DONE) ? result_word : mul_result_q;

    // Sequencer FSM with accumulator, iteration counter and held result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            m_q          <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            count_q      <= '0;
            mul_result_q <= '0;
            mul_done_q   <= 1'b0;
        end else begin
            mul_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mul_start) begin
                        m_q      <= ex_a;
                        acc_hi_q <= '0;
                        acc_lo_q <= ex_b;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    count_q  <= count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        state_q    <= DONE;
                        mul_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    mul_result_q <= result_word;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU model and a
// scoreboard: each multiply pushes its hand-computed result, and a monitor
// pops and compares on every mul_done pulse.
module tb_alu_mul_sequencer;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_alu_control;
    logic        mul_start, mul_hi_sel;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        stall, mul_done;
    logic [31:0] mul_result;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    alu_mul_sequencer dut (
        .clk(clk), .reset(reset),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
        .mul_start(mul_start), .mul_hi_sel(mul_hi_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result),
        .stall(stall), .mul_done(mul_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_control)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every mul_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && mul_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_mul_done", 32'd1, 32'd0);
            end else begin
                check("mul_result", mul_result, sb.pop_front());
            end
        end
    end

    logic [31:0] last_exp;

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic hi, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int pulse_at);
        int cycles;
        bit done;
        bit stall_ok;
        logic [31:0] exp;
`ifdef MUL_HIGH_EN
        exp = hi ? exp_hi : exp_lo;
`else
        exp = exp_lo;
        if (exp_hi == 32'hDEAD_BEEF) exp = 32'h0;
`endif
        last_exp = exp;
        @(posedge clk); #1;
        ex_a = a; ex_b = b; mul_hi_sel = hi; mul_start = 1'b1;
        sb.push_back(exp);
        #1 check("stall_cycle0", {31'b0, stall}, 32'd1);
        cycles = 0; done = 0; stall_ok = 1;
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            mul_start = (cycles == pulse_at);
            #1;
            if (cycles == 5) begin
                check("run_alu_control", {28'b0, alu_control}, {28'b0, OP_ADD});
                check("run_alu_b", alu_b, a);
            end
            if (mul_done) begin
                done = 1;
                check("done_stall", {31'b0, stall}, 32'd0);
            end else if (!stall) begin
                stall_ok = 0;
            end
        end
        mul_start = 1'b0;
        check("done_latency", cycles, 32'd33);
        check("stall_held_in_run", {31'b0, stall_ok}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; ex_a = '0; ex_b = '0; ex_alu_control = '0;
        mul_start = 1'b0; mul_hi_sel = 1'b0;
        #12;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_done", {31'b0, mul_done}, 32'd0);
        check("rst_result", mul_result, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Pass-through
        ex_a = 32'd7; ex_b = 32'd5; ex_alu_control = OP_SUB; #1;
        check("pt_a", alu_a, 32'd7);
        check("pt_b", alu_b, 32'd5);
        check("pt_ctl", {28'b0, alu_control}, {28'b0, OP_SUB});
        check("pt_stall", {31'b0, stall}, 32'd0);
        ex_a = 32'hA5A5_0F0F; ex_b = 32'h1234_5678; ex_alu_control = OP_OR; #1;
        check("pt2_a", alu_a, 32'hA5A5_0F0F);
        check("pt2_res", alu_result, 32'hB7B5_5F7F);

        // Directed multiplies: a, b, hi_sel, low word, high word
        run_mul(32'd3, 32'd5, 1'b0, 32'd15, 32'd0, -1);
        @(posedge clk); #1;
        check("result_hold", mul_result, last_exp);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, -1);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, -1);
        run_mul(32'h8000_0000, 32'd2, 1'b1, 32'h0000_0000, 32'h0000_0001, -1);
        run_mul(32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 32'h0000_0001, -1);
        run_mul(32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, -1);
        run_mul(32'd7, 32'd6, 1'b0, 32'd42, 32'd0, -1);
        // Back-to-back with a spurious start during RUN
        run_mul(32'd3, 32'd5, 1'b0, 32'd15, 32'd0, 10);
        repeat (3) @(posedge clk);

        // Reset mid-multiply
        @(posedge clk); #1;
        ex_a = 32'd11; ex_b = 32'd13; mul_start = 1'b1; mul_hi_sel = 1'b0;
        @(posedge clk); #1; mul_start = 1'b0;
        repeat (14) @(posedge clk);
        #1 ex_a = 32'd9; ex_alu_control = OP_AND; reset = 1'b1; #1;
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_done", {31'b0, mul_done}, 32'd0);
        check("midrst_pt_a", alu_a, 32'd9);
        check("midrst_pt_ctl", {28'b0, alu_control}, {28'b0, OP_AND});
        @(negedge clk); reset = 1'b0;
        run_mul(32'd3, 32'd5, 1'b0, 32'd15, 32'd0, -1);
        repeat (4) @(posedge clk);

        if (sb.size() != 0) check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

- Iterative shift-add multiplier controller for the EX stage.
- Shares the single 32-bit combinational ALU between the pipeline and a 32-iteration multiply.
- When idle, it passes the pipeline's ALU operands and control through untouched. On a multiply request it stalls the pipeline, drives the ALU with ADD operations each cycle and accumulates a 64-bit unsigned product. It then releases the stall for one cycle with the result valid.

## Interface
- XLEN, 32: datapath width; must equal ALU width (only 32 supported).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_a, ex_b  in  32  pipeline ALU operands.
- ex_alu_control  in  4  pipeline ALU opcode.
- mul_start  in  1  EX-stage instruction is a multiply; operands on ex_a (multiplicand), ex_b (multiplier).
- mul_hi_sel  in  1  select high word of product on mul_result (honoured only with macro).
- alu_a, alu_b  out  32  ALU operand drive.
- alu_control  out  4  ALU opcode drive.
- alu_result  in  32  ALU combinational result.
- stall  out  1  freeze IF/ID/EX.
- mul_done  out  1  one-cycle pulse; mul_result valid.
- mul_result  out  32  product word.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - ALU mux passes ex_a/ex_b/ex_alu_control.
  - On mul_start:
    - latch multiplicand M = ex_a;
    - init acc_hi = 0, acc_lo = ex_b, count = 0;
    - go to RUN.
  - stall is asserted combinationally in the mul_start cycle.
- RUN, each cycle:
  - alu_a = acc_hi, alu_b = M, alu_control = 4'b0010.
  - If acc_lo[0] = 1:
    - sum = alu_result;
    - carry = (sum < acc_hi), unsigned compare in this block, since the ALU has no carry out.
  - Else: sum = acc_hi, carry = 0.
  - Update {acc_hi, acc_lo} <= {carry, sum, acc_lo} >> 1 (65-bit shift, drop LSB).
  - count += 1.
  - At count == 31 (the 32nd RUN cycle) go to DONE.
  - stall = 1 throughout.
- DONE:
  - stall = 0, mul_done = 1.
  - mul_result = acc_lo, or acc_hi when selected per Configuration.
  - ALU mux back to pipeline.
  - Unconditionally go to IDLE.
- mul_start in RUN or DONE: ignored.
- No early termination; a zero operand still takes 32 iterations.
- The low word is correct for MUL regardless of operand sign. The high word is unsigned (MULHU semantics).
- Reset values (asynchronous, any state, including mid-RUN): state IDLE, acc_hi = acc_lo = M = 0, count = 0, stall = 0, mul_done = 0, mul_result = 0. The ALU mux returns to pass-through immediately.
- mul_result holds its value outside DONE; only sample it when mul_done = 1.

## Timing
- Cycle 0: IDLE with mul_start, stall = 1.
- Cycles 1–32: RUN, stall = 1.
- Cycle 33: DONE, stall = 0, mul_done = 1. The pipeline captures mul_result at the end of cycle 33.
- Total stall: 33 cycles; result latency: 33 cycles after start.
- Back-to-back multiplies: the next mul_start is accepted at cycle 34 (IDLE).
- Pass-through path is purely combinational, with zero added latency.
- mul_done is registered-state-derived. stall depends combinationally on mul_start only in IDLE.

## Configuration
- MUL_HIGH_EN defined:
  - mul_result = mul_hi_sel ? acc_hi : acc_lo in DONE.
  - Supports MULHU.
- MUL_HIGH_EN undefined:
  - mul_hi_sel is ignored and mul_result is always acc_lo.
  - acc_hi is still required internally for the iteration.

## Structure
- Shared package:
  - ALU opcode constants ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
  - state enum {IDLE, RUN, DONE};
  - MUL_ITERS = 32.
- Single module; no sub-module required. The ALU is instantiated by the EX stage, not inside this block.

## Test plan
- Idle pass-through: ex_a = 7, ex_b = 5, ex_alu_control = 0110, mul_start = 0 -> alu_a = 7, alu_b = 5, alu_control = 0110, stall = 0.
- 3 × 5: start at cycle 0 -> stall cycles 0–32, mul_done at cycle 33, mul_result = 15.
- 0xFFFFFFFF × 0xFFFFFFFF -> low = 0x00000001; with MUL_HIGH_EN and mul_hi_sel = 1, high = 0xFFFFFFFE.
- 0x80000000 × 2 -> low = 0x00000000; high (MUL_HIGH_EN) = 0x00000001 (carry path).
- mul_start pulsed again at cycle 10 during RUN -> ignored; single mul_done at cycle 33.
- reset asserted at cycle 15 of a multiply -> stall = 0, mul_done = 0 immediately, state IDLE. A new 3 × 5 then completes 33 cycles after its start.
